// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32M op/state types for the iterative mul/div unit
package riscv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_e;

    localparam logic [6:0] RV32M_FUNCT7 = 7'b0000001;

    function automatic logic op_a_signed(input muldiv_op_e op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_b_signed(input muldiv_op_e op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/riscv_negate.sv
// rtl/riscv_negate.sv - conditional two's complement
module riscv_negate #(
    parameter int WIDTH = 32
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    assign o_data = i_en ? (~i_data + WIDTH'(1)) : i_data;

endmodule

// File: rtl/riscv_muldiv.sv
// rtl/riscv_muldiv.sv - iterative RV32M multiply/divide, fixed XLEN+2 cycle latency
module riscv_muldiv
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNTW = $clog2(XLEN) + 1;

    muldiv_state_e     r_state;
    muldiv_state_e     w_state_next;
    muldiv_op_e        r_op;
    logic              r_neg;
    logic              r_bzero;
    logic              r_ovf;
    logic [XLEN-1:0]   r_a_raw;
    logic [XLEN-1:0]   r_opa;
    logic [XLEN-1:0]   r_opb;
    logic [2*XLEN-1:0] r_acc;
    logic [CNTW-1:0]   r_cnt;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    muldiv_op_e        w_op;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_last;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN-1:0]   w_trial;
    logic              w_trial_ok;
    logic [2*XLEN-1:0] w_fix_in;
    logic [2*XLEN-1:0] w_fix;
    logic [XLEN-1:0]   w_sel;

    assign w_op   = muldiv_op_e'(funct3);
    assign w_sa   = op_a_signed(w_op) & a[XLEN-1];
    assign w_sb   = op_b_signed(w_op) & b[XLEN-1];
    assign w_last = (r_cnt == CNTW'(XLEN - 1));

    riscv_negate #(.WIDTH(XLEN)) u_neg_a (
        .i_en   (w_sa),
        .i_data (a),
        .o_data (w_abs_a)
    );

    riscv_negate #(.WIDTH(XLEN)) u_neg_b (
        .i_en   (w_sb),
        .i_data (b),
        .o_data (w_abs_b)
    );

    // Multiply: r_opa = multiplicand, r_opb = multiplier shifted right.
    // Divide:   r_opa = dividend shifted out MSB-first, r_opb = divisor,
    //           accumulator high half = remainder, low half = quotient.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_opb[0] ? r_opa : '0)};
    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_opa[XLEN-1]};
    assign w_trial_ok = (w_rem_sh >= {1'b0, r_opb});
    assign w_trial    = w_rem_sh[XLEN-1:0] - r_opb;

    always_comb begin
        w_fix_in = r_acc;
        if (r_op == REM || r_op == REMU) begin
            w_fix_in = {{XLEN{1'b0}}, r_acc[2*XLEN-1:XLEN]};
        end else if (r_op == DIV || r_op == DIVU) begin
            w_fix_in = {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
        end
    end

    riscv_negate #(.WIDTH(2*XLEN)) u_neg_fix (
        .i_en   (r_neg),
        .i_data (w_fix_in),
        .o_data (w_fix)
    );

    always_comb begin
        w_sel = w_fix[XLEN-1:0];
        case (r_op)
            MUL:                w_sel = w_fix[XLEN-1:0];
            MULH, MULHSU, MULHU: w_sel = w_fix[2*XLEN-1:XLEN];
            DIV, DIVU: begin
                if (r_bzero)    w_sel = '1;
                else if (r_ovf) w_sel = r_a_raw;
                else            w_sel = w_fix[XLEN-1:0];
            end
            REM, REMU: begin
                if (r_bzero)    w_sel = r_a_raw;
                else if (r_ovf) w_sel = '0;
                else            w_sel = w_fix[XLEN-1:0];
            end
            default:            w_sel = w_fix[XLEN-1:0];
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN: begin
                if (flush)       w_state_next = IDLE;
                else if (w_last) w_state_next = FIX;
            end
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_op     <= MUL;
            r_neg    <= 1'b0;
            r_bzero  <= 1'b0;
            r_ovf    <= 1'b0;
            r_a_raw  <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op    <= w_op;
                        r_neg   <= (w_op == REM || w_op == REMU) ? w_sa : (w_sa ^ w_sb);
                        r_bzero <= (b == '0);
                        r_ovf   <= (w_op == DIV || w_op == REM) &&
                                   (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
                        r_a_raw <= a;
                        r_opa   <= w_abs_a;
                        r_opb   <= w_abs_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + CNTW'(1);
                    if (r_op == DIV || r_op == DIVU || r_op == REM || r_op == REMU) begin
                        r_acc <= {(w_trial_ok ? w_trial : w_rem_sh[XLEN-1:0]),
                                  r_acc[XLEN-2:0], w_trial_ok};
                        r_opa <= {r_opa[XLEN-2:0], 1'b0};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
                        r_opb <= {1'b0, r_opb[XLEN-1:1]};
                    end
                end
                FIX: begin
                    if (!flush) begin
                        r_result <= w_sel;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_riscv_muldiv.sv
// tb/tb_riscv_muldiv.sv - randomized and directed self-checking bench for riscv_muldiv
module tb_riscv_muldiv;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int total = 0;
    int bad   = 0;

    riscv_muldiv #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
        longint      sa = longint'($signed(av));
        longint      sb = longint'($signed(bv));
        logic [63:0] ua = {32'b0, av};
        logic [63:0] ub = {32'b0, bv};
        logic [63:0] p;
        logic        ovf = (av == 32'h8000_0000) && (bv == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (bv == 0) return 32'hFFFF_FFFF;
                if (ovf) return av;
                return 32'($signed(av) / $signed(bv));
            end
            3'd5: return (bv == 0) ? 32'hFFFF_FFFF : av / bv;
            3'd6: begin
                if (bv == 0) return av;
                if (ovf) return 32'd0;
                return 32'($signed(av) % $signed(bv));
            end
            default: return (bv == 0) ? av : av % bv;
        endcase
    endfunction

    // Starts an op in the current cycle (cycle 0) and returns sampled in its done cycle.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp, input bit hold);
        int done_cyc = -1;
        int ndone    = 0;
        int busy_err = 0;
        funct3 = f;
        a      = av;
        b      = bv;
        start  = 1'b1;
        for (int c = 1; c <= XLEN + 2; c++) begin
            @(posedge clk);
            #1;
            if (!hold && c == 1) start = 1'b0;
            if (c == XLEN + 2) start = 1'b0;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy !== (c <= XLEN + 1)) busy_err++;
        end
        check({tag, "_done_cyc"}, 64'(done_cyc), 64'(XLEN + 2));
        check({tag, "_ndone"}, 64'(ndone), 64'd1);
        check({tag, "_busy"}, 64'(busy_err), 64'd0);
        check({tag, "_res"}, 64'(result), 64'(exp));
    endtask

    task automatic idle_check(input string tag, input int n, input logic [31:0] exp_res);
        int ndone = 0;
        int nbusy = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (busy) nbusy++;
        end
        check({tag, "_idle_done"}, 64'(ndone), 64'd0);
        check({tag, "_idle_busy"}, 64'(nbusy), 64'd0);
        check({tag, "_idle_res"}, 64'(result), 64'(exp_res));
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] sp [5] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    logic [2:0]  d_f   [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

    initial begin
        logic [31:0] held;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        reset  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        a      = '0;
        b      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_res", 64'(result), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("dir%0d", i), d_f[i], d_a[i], d_b[i], d_exp[i], 1'b0);
        end

        run_op("b2b_divu", 3'd5, 32'd9, 32'd3, 32'd3, 1'b0);
        run_op("b2b_mul", 3'd0, 32'd6, 32'd7, 32'd42, 1'b0);
        idle_check("b2b", 5, 32'd42);

        run_op("hold", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0,
               ref_model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1);
        idle_check("hold", 40, ref_model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));

        held   = result;
        funct3 = 3'd4;
        a      = 32'd1000;
        b      = 32'd3;
        start  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_res", 64'(result), 64'(held));
        idle_check("flush", 40, held);

        funct3 = 3'd0;
        a      = 32'd123;
        b      = 32'd456;
        start  = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_res", 64'(result), 64'd0);
        idle_check("mrst", 40, 32'd0);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            run_op($sformatf("rnd%0d_f%0d_%h_%h", i, rf, ra, rb), rf, ra, rb, ref_model(rf, ra, rb), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
